rec_play_ctrl: RTL

- Top-level sequencer for the audio recorder/player.
- Turns debounced single-cycle key pulses into the 3-bit top_state bus consumed by the SRAM buffer and the I2S/DSP blocks. Bit 2 selects record (1) or play (0); bits [1:0] give the phase.
- Also owns the playback speed setting, the interpolation-mode flag and the elapsed-seconds counter shown on the 7-segment display.

---
 rtl/rec_play_ctrl_pkg.sv | 29 ++
 rtl/rec_play_ctrl_if.sv | 34 +++
 rtl/rec_play_ctrl_sec_timer.sv | 49 ++++
 rtl/rec_play_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rec_play_ctrl_pkg.sv
// Shared types and constants for the recorder/player sequencer.
//   phase_e     : transport phase, also the low two bits of top_state
//   MODE_*      : top_state bit 2 (record vs play)
//   speed_idx_t : signed playback speed index, limited to SPEED_MIN..SPEED_MAX
//   speed_mag   : magnitude of a speed index, as shown on o_speed
package rec_play_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } phase_e;

    localparam logic MODE_PLAY = 1'b0;
    localparam logic MODE_REC  = 1'b1;

    typedef logic signed [3:0] speed_idx_t;

    localparam speed_idx_t SPEED_MAX = 4'sd7;
    localparam speed_idx_t SPEED_MIN = -4'sd7;

    function automatic logic [2:0] speed_mag(input speed_idx_t idx);
        speed_idx_t neg;
        neg = -idx;
        return idx[3] ? neg[2:0] : idx[2:0];
    endfunction

endpackage

// File: rtl/rec_play_ctrl_if.sv
// Key/status bundle between the front panel and the sequencer.
//   i_key_*     : single-cycle debounced key pulses
//   i_full      : buffer full (record) / playback reached recorded length (play)
//   o_top_state : {mode, phase}
//   o_fast, o_speed, o_interp : playback speed and interpolation settings
//   o_sec       : elapsed seconds of the current take
// master = panel/stimulus side, slave = sequencer side.
interface rec_play_ctrl_if;
    logic       i_key_record;
    logic       i_key_play;
    logic       i_key_pause;
    logic       i_key_stop;
    logic       i_key_fast;
    logic       i_key_slow;
    logic       i_key_interp;
    logic       i_full;
    logic [2:0] o_top_state;
    logic       o_fast;
    logic [2:0] o_speed;
    logic       o_interp;
    logic [5:0] o_sec;

    modport master (
        output i_key_record, i_key_play, i_key_pause, i_key_stop,
               i_key_fast, i_key_slow, i_key_interp, i_full,
        input  o_top_state, o_fast, o_speed, o_interp, o_sec
    );

    modport slave (
        input  i_key_record, i_key_play, i_key_pause, i_key_stop,
               i_key_fast, i_key_slow, i_key_interp, i_full,
        output o_top_state, o_fast, o_speed, o_interp, o_sec
    );
endinterface

// File: rtl/rec_play_ctrl_sec_timer.sv
// Elapsed-time counter for the 7-segment display.
//   i_clk, i_rst : clock, async active-high reset
//   i_run        : count this cycle (transport in RUN)
//   i_clear      : zero both counters (take is starting)
//   o_sec        : whole seconds, saturating at MAX_SEC
module sec_timer #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int MAX_SEC     = 63
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_clear,
    output logic [5:0] o_sec
);
    localparam int SW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    logic [SW-1:0] sub_q, sub_d;
    logic [5:0]    sec_q, sec_d;

    always_comb begin
        sub_d = sub_q;
        sec_d = sec_q;
        if (i_clear) begin
            sub_d = '0;
            sec_d = '0;
        end else if (i_run) begin
            if (sub_q == SW'(CLK_PER_SEC - 1)) begin
                sub_d = '0;
                if (sec_q != 6'(MAX_SEC))
                    sec_d = sec_q + 6'd1;
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sub_q <= '0;
            sec_q <= '0;
        end else begin
            sub_q <= sub_d;
            sec_q <= sec_d;
        end
    end

    assign o_sec = sec_q;
endmodule

// File: rtl/rec_play_ctrl.sv
// Top-level sequencer of the audio recorder/player.
//   i_clk, i_rst : clock, async active-high reset
//   bus (slave)  : key pulses and i_full in; top_state, speed, interp and
//                  seconds out (all registered)
// The transport FSM, speed index and interpolation flag live here; the
// seconds counter is in sec_timer.
module rec_play_ctrl
    import rec_play_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int FULL_GUARD  = 2,
    parameter int MAX_SEC     = 63
) (
    input logic            i_clk,
    input logic            i_rst,
    rec_play_ctrl_if.slave bus
);
    localparam int GW = $clog2(FULL_GUARD + 1) + 1;

    phase_e     phase_q, phase_d;
    logic       mode_q, mode_d;
    logic [GW-1:0] guard_q, guard_d;
    speed_idx_t idx_q, idx_d;
    logic       fast_q, fast_d;
    logic [2:0] speed_q, speed_d;
    logic       interp_q;
    logic       full_ok;
    logic       resume_key;
    logic [5:0] sec;

    // i_full only counts once the buffer has had FULL_GUARD RUN cycles to
    // move its pointers away from the stale full condition.
    assign full_ok = (guard_q >= GW'(FULL_GUARD));

    // Resume from PAUSE: pause toggle, or the transport key of the current mode.
    assign resume_key = bus.i_key_pause
                      | (bus.i_key_record & (mode_q == MODE_REC))
                      | (bus.i_key_play   & (mode_q == MODE_PLAY));

    always_comb begin
        phase_d = phase_q;
        mode_d  = mode_q;
        unique case (phase_q)
            IDLE: begin
                if (bus.i_key_record) begin
                    phase_d = START;
                    mode_d  = MODE_REC;
                end else if (bus.i_key_play) begin
                    phase_d = START;
                    mode_d  = MODE_PLAY;
                end
            end
            START: phase_d = RUN;
            RUN: begin
                if (bus.i_key_stop || (bus.i_full && full_ok))
                    phase_d = IDLE;
                else if (bus.i_key_pause)
                    phase_d = PAUSE;
            end
            PAUSE: begin
                if (bus.i_key_stop)
                    phase_d = IDLE;
                else if (resume_key)
                    phase_d = RUN;
            end
            default: phase_d = IDLE;
        endcase
    end

    // Guard counter is held at zero outside RUN so every RUN entry restarts it.
    always_comb begin
        guard_d = '0;
        if (phase_q == RUN)
            guard_d = full_ok ? guard_q : guard_q + GW'(1);
    end

    // Simultaneous fast+slow cancels out.
    always_comb begin
        idx_d = idx_q;
        if (bus.i_key_fast && !bus.i_key_slow && idx_q != SPEED_MAX)
            idx_d = idx_q + 4'sd1;
        else if (bus.i_key_slow && !bus.i_key_fast && idx_q != SPEED_MIN)
            idx_d = idx_q - 4'sd1;
        fast_d  = ~idx_d[3];
        speed_d = speed_mag(idx_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q  <= IDLE;
            mode_q   <= MODE_PLAY;
            guard_q  <= '0;
            idx_q    <= '0;
            fast_q   <= 1'b1;
            speed_q  <= '0;
            interp_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            guard_q  <= guard_d;
            idx_q    <= idx_d;
            fast_q   <= fast_d;
            speed_q  <= speed_d;
            interp_q <= interp_q ^ bus.i_key_interp;
        end
    end

    sec_timer #(
        .CLK_PER_SEC(CLK_PER_SEC),
        .MAX_SEC    (MAX_SEC)
    ) u_sec_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_run  (phase_q == RUN),
        .i_clear(phase_q == START),
        .o_sec  (sec)
    );

    assign bus.o_top_state = {mode_q, phase_q};
    assign bus.o_fast      = fast_q;
    assign bus.o_speed     = speed_q;
    assign bus.o_interp    = interp_q;
    assign bus.o_sec       = sec;
endmodule
